// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, 2-entry {pc,inst} queue, redirect flush
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count decode-transfer counter.
module fetch_unit #(
  parameter logic [63:0] STARTPC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  count;
  logic [63:0] pc0, pc1;
  logic [31:0] inst0, inst1;

  logic        pop, grant, rsp, push;
  logic [2:0]  occ;
  logic [1:0]  inflight;
  logic [63:0] rsp_pc;
  logic        unused_lsb;

  // low target bits are discarded by word alignment
  assign unused_lsb = ^redirect_pc[1:0];

  assign imem_addr  = pc;
  assign inst_valid = (count != 2'd0);
  assign inst       = inst0;
  assign inst_pc    = pc0;

  assign pop      = inst_valid && inst_ready && !redirect;
  assign occ      = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
  assign imem_req = (state == FETCH) && !redirect && (occ < 3'd2);
  assign grant    = imem_req && imem_gnt;
  // a response with nothing in flight (stale traffic after reset) is ignored
  assign rsp      = imem_rvalid && (state != IDLE) && ((outstanding != 2'd0) || (drop != 2'd0));
  assign push     = rsp && (state == FETCH) && !redirect;
  // requests since the last redirect are contiguous, so the oldest one sits behind pc
  assign rsp_pc   = pc - {60'd0, outstanding, 2'b00};
  assign inflight = outstanding + drop - {1'b0, rsp};

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= IDLE;
      pc          <= STARTPC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      count       <= 2'd0;
      pc0         <= 64'd0;
      pc1         <= 64'd0;
      inst0       <= 32'd0;
      inst1       <= 32'd0;
    end else if (redirect) begin
      pc          <= {redirect_pc[63:2], 2'b00};
      count       <= 2'd0;
      outstanding <= 2'd0;
      drop        <= inflight;
      state       <= (inflight != 2'd0) ? FLUSH : FETCH;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (grant) pc <= pc + 64'd4;
          case ({grant, push})
            2'b10:   outstanding <= outstanding + 2'd1;
            2'b01:   outstanding <= outstanding - 2'd1;
            default: ;
          endcase
        end
        FLUSH: begin
          if (rsp) begin
            drop <= drop - 2'd1;
            if (drop == 2'd1) state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      // slot 0 is always the head, so decode outputs come straight from registers
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            pc0   <= rsp_pc;
            inst0 <= imem_rdata;
          end else begin
            pc1   <= rsp_pc;
            inst1 <= imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0   <= pc1;
          inst0 <= inst1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            pc0   <= rsp_pc;
            inst0 <= imem_rdata;
          end else begin
            pc0   <= pc1;
            inst0 <= inst1;
            pc1   <= rsp_pc;
            inst1 <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)  fetch_count <= 32'd0;
    else if (pop)  fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
